// File: rtl/jh_fdtd_sequencer.sv
// jh_fdtd_sequencer: run controller for the PE4FDTD array.
// Serializes host word writes/reads onto the shared PE load bus, sequences
// a run (PE clear, computing_on for the programmed iterations, settle tail),
// and reports busy/done/timeout plus the elapsed run cycle count.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   cmd_valid/ready/op/pe/addr/data   host command channel
//                                op: 0=WRITE 1=READ 2=RUN 3=ABORT
//   rsp_valid, rsp_data          READ response (pulse / held data)
//   pe_target/addr/data/we       shared PE load bus
//   pe_rst                       synchronous clear to all PEs
//   computing_on, iteration_num  run control to all PEs
//   finish_all, pe_rdata         status/readback from the PE array
//   busy, done, timeout          controller status
//   run_cycles                   cycles computing_on was high in last run
module jh_fdtd_sequencer #(
  parameter int unsigned NUM_PE   = 20,
  parameter int unsigned Z_SIZE   = 110,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned SETTLE   = 16,
  parameter logic [31:0] TIMEOUT  = 32'd2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_pe,
  input  logic [6:0]  cmd_addr,
  input  logic [26:0] cmd_data,
  output logic        rsp_valid,
  output logic [26:0] rsp_data,
  output logic [5:0]  pe_target,
  output logic [6:0]  pe_addr,
  output logic [26:0] pe_data,
  output logic        pe_we,
  output logic        pe_rst,
  output logic        computing_on,
  output logic [15:0] iteration_num,
  input  logic        finish_all,
  input  logic [26:0] pe_rdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] run_cycles
);

  localparam int unsigned PE_W   = 6;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned RC_W   = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_ABORT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_WAIT, S_CLR, S_RUN, S_SETTLE, S_ABORT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               rd_drop;

  logic               cmd_fire;
  logic               cmd_in_range;
  logic               abort_req;
  logic [RC_W-1:0]    run_cycles_inc;
  logic               wdog_hit;

  // Only ABORT may enter while a run is in flight; everything else stalls.
  assign cmd_ready = (state == S_IDLE) ||
                     (((state == S_RUN) || (state == S_SETTLE)) && (cmd_op == OP_ABORT));

  assign cmd_fire     = cmd_valid && cmd_ready;
  assign cmd_in_range = (cmd_pe < PE_W'(NUM_PE)) && (cmd_addr < ADDR_W'(Z_SIZE));
  assign abort_req    = cmd_valid && (cmd_op == OP_ABORT);

  // Saturating elapsed-cycle count and watchdog compare on the next value.
  assign run_cycles_inc = (&run_cycles) ? run_cycles : run_cycles + RC_W'(1);
  assign wdog_hit       = (run_cycles_inc >= TIMEOUT);

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      rd_drop       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      pe_target     <= '0;
      pe_addr       <= '0;
      pe_data       <= '0;
      pe_we         <= 1'b0;
      pe_rst        <= 1'b0;
      computing_on  <= 1'b0;
      iteration_num <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      run_cycles    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_WRITE: begin
                // Out-of-range writes are accepted and silently dropped.
                if (cmd_in_range) begin
                  pe_target <= cmd_pe;
                  pe_addr   <= cmd_addr;
                  pe_data   <= cmd_data;
                  pe_we     <= 1'b1;
                  state     <= S_WR;
                  busy      <= 1'b1;
                end
              end
              OP_READ: begin
                // Dropped reads keep the bus still and answer zero.
                rd_drop <= !cmd_in_range;
                if (cmd_in_range) begin
                  pe_target <= cmd_pe;
                  pe_addr   <= cmd_addr;
                end
                pe_we <= 1'b0;
                cnt   <= '0;
                state <= S_RD_WAIT;
                busy  <= 1'b1;
              end
              OP_RUN: begin
                iteration_num <= cmd_data[15:0];
                done          <= 1'b0;
                timeout       <= 1'b0;
                run_cycles    <= '0;
                if (cmd_data[15:0] == '0) begin
                  done <= 1'b1;
                end else begin
                  pe_rst <= 1'b1;
                  cnt    <= '0;
                  state  <= S_CLR;
                  busy   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        S_WR: begin
          pe_we <= 1'b0;
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        S_RD_WAIT: begin
          if (cnt == CNT_W'(READ_LAT - 1)) begin
            rsp_data  <= rd_drop ? '0 : pe_rdata;
            rsp_valid <= 1'b1;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_CLR: begin
          if (cnt == CNT_W'(1)) begin
            pe_rst       <= 1'b0;
            computing_on <= 1'b1;
            state        <= S_RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RUN: begin
          run_cycles <= run_cycles_inc;
          if (abort_req || wdog_hit) begin
            computing_on <= 1'b0;
            pe_rst       <= 1'b1;
            timeout      <= wdog_hit;
            cnt          <= '0;
            state        <= S_ABORT;
          end else if (finish_all) begin
            // The cycle finish_all is seen already counts toward the settle tail.
            if (SETTLE <= 1) begin
              computing_on <= 1'b0;
              done         <= 1'b1;
              state        <= S_IDLE;
              busy         <= 1'b0;
            end else begin
              cnt   <= CNT_W'(1);
              state <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          run_cycles <= run_cycles_inc;
          if (abort_req || wdog_hit) begin
            computing_on <= 1'b0;
            pe_rst       <= 1'b1;
            timeout      <= wdog_hit;
            cnt          <= '0;
            state        <= S_ABORT;
          end else if (cnt == CNT_W'(SETTLE - 1)) begin
            computing_on <= 1'b0;
            done         <= 1'b1;
            state        <= S_IDLE;
            busy         <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_ABORT: begin
          if (cnt == CNT_W'(1)) begin
            pe_rst <= 1'b0;
            state  <= S_IDLE;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jh_fdtd_sequencer.sv
// Testbench for jh_fdtd_sequencer: directed steps, a PE-array stub on the
// load bus, and a scoreboard of expected READ responses with arrival cycle.
module tb_jh_fdtd_sequencer;

  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_pe;
  logic [6:0]  cmd_addr;
  logic [26:0] cmd_data;
  logic        rsp_valid;
  logic [26:0] rsp_data;
  logic [5:0]  pe_target;
  logic [6:0]  pe_addr;
  logic [26:0] pe_data;
  logic        pe_we;
  logic        pe_rst;
  logic        computing_on;
  logic [15:0] iteration_num;
  logic        finish_all;
  logic [26:0] pe_rdata;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] run_cycles;

  typedef struct {
    logic [26:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [26:0] model  [64][128];
  logic [26:0] pe_mem [64][128];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          unexp = 0;
  int          bus_clash = 0;

  jh_fdtd_sequencer #(
    .NUM_PE(20), .Z_SIZE(110), .READ_LAT(READ_LAT), .SETTLE(16), .TIMEOUT(32'd1000)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_pe(cmd_pe), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .pe_target(pe_target), .pe_addr(pe_addr), .pe_data(pe_data), .pe_we(pe_we),
    .pe_rst(pe_rst), .computing_on(computing_on), .iteration_num(iteration_num),
    .finish_all(finish_all), .pe_rdata(pe_rdata),
    .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PE array stub: writes from the bus, one registered readback stage.
  always @(posedge clk) begin
    if (pe_we) pe_mem[pe_target][pe_addr] <= pe_data;
    pe_rdata <= pe_mem[pe_target][pe_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard and bus-during-run monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (pe_we && computing_on) bus_clash++;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          unexp++;
        end else begin
          e = sb.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Present a command at a negedge, wait until accepted, return at the negedge after.
  task automatic issue(input logic [1:0] op, input logic [5:0] pe, input logic [6:0] addr,
                       input logic [26:0] data);
    int   n = 0;
    exp_t e;
    logic in_range;
    cmd_valid = 1'b1; cmd_op = op; cmd_pe = pe; cmd_addr = addr; cmd_data = data;
    #1;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk); #1; n++;
    end
    check("issue_ready", 32'(cmd_ready), 1);
    in_range = (pe < 6'd20) && (addr < 7'd110);
    if (op == 2'd1) begin
      e.data = in_range ? model[pe][addr] : 27'd0;
      e.cyc  = cyc + 1 + READ_LAT;
      sb.push_back(e);
    end
    if (op == 2'd0 && in_range) model[pe][addr] = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk); n++;
    end
    check("wait_idle", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cnt;
    int prst;
    int viol;
    int n;
    logic queued;
    logic accepted;

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_pe = '0; cmd_addr = '0;
    cmd_data = '0; finish_all = 1'b0;

    // Reset values
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_computing_on", 32'(computing_on), 0);
    check("rst_pe_rst", 32'(pe_rst), 0);
    check("rst_pe_we", 32'(pe_we), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_iteration_num", 32'(iteration_num), 0);
    @(negedge clk); rst = 1'b1; @(negedge clk);

    // Word write: one cycle of pe_we with the command on the bus
    issue(2'd0, 6'd3, 7'd5, 27'h1ABCDEF);
    check("wr_we", 32'(pe_we), 1);
    check("wr_target", 32'(pe_target), 3);
    check("wr_addr", 32'(pe_addr), 5);
    check("wr_data", 32'(pe_data), 32'h1ABCDEF);
    check("wr_busy", 32'(busy), 1);
    @(negedge clk);
    check("wr_we_end", 32'(pe_we), 0);
    check("wr_idle", 32'(busy), 0);
    issue(2'd0, 6'd19, 7'd109, 27'h0F0F0F1);
    issue(2'd0, 6'd0, 7'd0, 27'h7FFFFFF);
    wait_idle();

    // Reads, including the top-corner PE/address
    issue(2'd1, 6'd3, 7'd5, 27'd0);
    check("rd_we", 32'(pe_we), 0);
    check("rd_target", 32'(pe_target), 3);
    check("rd_busy", 32'(busy), 1);
    wait_idle();
    issue(2'd1, 6'd19, 7'd109, 27'd0);
    wait_idle();
    issue(2'd1, 6'd0, 7'd0, 27'd0);
    wait_idle();

    // Out-of-range reads answer zero; out-of-range writes never reach the bus
    issue(2'd1, 6'd25, 7'd0, 27'd0);
    check("oor_rd_we", 32'(pe_we), 0);
    wait_idle();
    issue(2'd1, 6'd2, 7'd110, 27'd0);
    wait_idle();
    issue(2'd0, 6'd20, 7'd1, 27'h123);
    check("oor_wr_we_pe", 32'(pe_we), 0);
    issue(2'd0, 6'd4, 7'd127, 27'h456);
    check("oor_wr_we_addr", 32'(pe_we), 0);
    check("oor_wr_busy", 32'(busy), 0);

    // RUN with zero iterations completes immediately
    issue(2'd2, 6'd0, 7'd0, 27'd0);
    check("run0_done", 32'(done), 1);
    check("run0_busy", 32'(busy), 0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (computing_on) cnt++;
    end
    check("run0_computing", 32'(cnt), 0);

    // RUN 100, finish_all raised 500 cycles after computing_on rises
    issue(2'd2, 6'd0, 7'd0, 27'd100);
    check("run_clr1", 32'(pe_rst), 1);
    check("run_busy", 32'(busy), 1);
    check("run_done_cleared", 32'(done), 0);
    check("run_iter", 32'(iteration_num), 100);
    check("run_clr1_comp", 32'(computing_on), 0);
    @(negedge clk);
    check("run_clr2", 32'(pe_rst), 1);
    @(negedge clk);
    check("run_clr_end", 32'(pe_rst), 0);
    check("run_comp_on", 32'(computing_on), 1);
    cnt = 1; n = 0;
    while (n < 2000) begin
      if (cnt == 501 && !finish_all) finish_all = 1'b1;
      @(negedge clk); n++;
      if (computing_on) cnt++;
      if (!busy) break;
    end
    finish_all = 1'b0;
    check("run_on_cycles", 32'(cnt), 516);
    check("run_cycles_516", run_cycles, 516);
    check("run_done", 32'(done), 1);
    check("run_no_timeout", 32'(timeout), 0);
    check("run_comp_off", 32'(computing_on), 0);
    check("run_iter_stable", 32'(iteration_num), 100);

    // Watchdog expiry with a WRITE stalled behind the run
    issue(2'd2, 6'd0, 7'd0, 27'd7);
    @(negedge clk); @(negedge clk);
    cnt = 1; prst = 0; viol = 0; n = 0; queued = 1'b0; accepted = 1'b0;
    while (n < 3000) begin
      if (cnt == 100 && !queued) begin
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_pe = 6'd1; cmd_addr = 7'd2;
        cmd_data = 27'h2468ACE; queued = 1'b1;
      end
      @(negedge clk); #1; n++;
      if (computing_on) cnt++;
      if (pe_rst) prst++;
      if (cmd_valid && busy && cmd_ready) viol++;
      if (cmd_valid && cmd_ready) begin
        model[1][2] = 27'h2468ACE;
        check("tmo_cycles_at_accept", run_cycles, 1000);
        check("tmo_flag", 32'(timeout), 1);
        check("tmo_no_done", 32'(done), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        accepted = 1'b1;
        check("q_wr_we", 32'(pe_we), 1);
        check("q_wr_data", 32'(pe_data), 32'h2468ACE);
        break;
      end
    end
    check("q_wr_accepted", 32'(accepted), 1);
    check("tmo_on_cycles", 32'(cnt), 1000);
    check("tmo_pe_rst_cycles", 32'(prst), 2);
    check("tmo_stall_ready", 32'(viol), 0);
    wait_idle();
    issue(2'd1, 6'd1, 7'd2, 27'd0);
    wait_idle();

    // ABORT 50 cycles into a run
    issue(2'd2, 6'd0, 7'd0, 27'd5);
    @(negedge clk); @(negedge clk);
    cnt = 1; n = 0;
    while (cnt < 50 && n < 200) begin
      @(negedge clk); n++;
      if (computing_on) cnt++;
    end
    cmd_valid = 1'b1; cmd_op = 2'd3;
    #1;
    check("ab_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("ab_comp_off", 32'(computing_on), 0);
    check("ab_prst1", 32'(pe_rst), 1);
    @(negedge clk);
    check("ab_prst2", 32'(pe_rst), 1);
    @(negedge clk);
    check("ab_prst_end", 32'(pe_rst), 0);
    check("ab_idle", 32'(busy), 0);
    check("ab_no_done", 32'(done), 0);
    check("ab_no_timeout", 32'(timeout), 0);
    check("ab_run_cycles", run_cycles, 50);
    issue(2'd0, 6'd7, 7'd7, 27'h0000055);
    check("ab_wr_we", 32'(pe_we), 1);
    wait_idle();
    issue(2'd1, 6'd7, 7'd7, 27'd0);
    wait_idle();

    // Asynchronous reset during SETTLE
    issue(2'd2, 6'd0, 7'd0, 27'd3);
    @(negedge clk); @(negedge clk);
    finish_all = 1'b1;
    repeat (4) @(negedge clk);
    check("settle_busy", 32'(busy), 1);
    check("settle_comp", 32'(computing_on), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_comp", 32'(computing_on), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_run_cycles", run_cycles, 0);
    check("arst_iter", 32'(iteration_num), 0);
    check("arst_pe_rst", 32'(pe_rst), 0);
    finish_all = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("arst_ready_after", 32'(cmd_ready), 1);
    check("arst_done", 32'(done), 0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    check("unexpected_rsp", 32'(unexp), 0);
    check("bus_during_run", 32'(bus_clash), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
